// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with exact fill count, programmable almost-full/almost-empty,
// standard or first-word-fall-through read, synchronous flush and sticky error flags.
//
// Parameters:
//   data_size        word width in bits
//   addr_size        address width; depth = 2**addr_size
//   almost_full_th   almost_full when fill_count >= this (1..depth)
//   almost_empty_th  almost_empty when fill_count <= this (0..depth-1)
//   fwft             0 = registered read, 1 = first-word-fall-through
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   write_en/data    push request and data
//   read_en          pop request (fwft: acknowledge of the presented head word)
//   flush            synchronous empty command; suppresses concurrent push/pop
//   clear_err        synchronous clear of overflow/underflow (a new set wins)
//   read_data/valid  popped or head word and its qualifier
//   fifo_full/empty, almost_full/empty  decodes of the registered fill_count
//   fill_count       words stored, 0..depth
//   overflow         sticky: write attempted while full
//   underflow        sticky: read attempted while empty
module sync_fifo #(
    parameter int data_size       = 8,
    parameter int addr_size       = 3,
    parameter int almost_full_th  = 6,
    parameter int almost_empty_th = 1,
    parameter int fwft            = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write_en,
    input  logic [data_size-1:0] write_data,
    input  logic                 read_en,
    input  logic                 flush,
    input  logic                 clear_err,
    output logic [data_size-1:0] read_data,
    output logic                 read_valid,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [addr_size:0]   fill_count,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int CW = addr_size + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1 << addr_size);
    localparam logic [CW-1:0] AF_TH = CW'(almost_full_th);
    localparam logic [CW-1:0] AE_TH = CW'(almost_empty_th);

    logic [data_size-1:0] mem_q [0:(1<<addr_size)-1];
    logic [addr_size-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [data_size-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                 wr_acc, rd_acc;

    always_comb begin
        fifo_full    = cnt_q == DEPTH;
        fifo_empty   = cnt_q == '0;
        almost_full  = cnt_q >= AF_TH;
        almost_empty = cnt_q <= AE_TH;
        fill_count   = cnt_q;
        overflow     = ovf_q;
        underflow    = udf_q;
        wr_acc       = write_en && !fifo_full && !flush;
        rd_acc       = read_en && !fifo_empty && !flush;
        wr_ptr_d     = flush ? '0 : wr_acc ? wr_ptr_q + addr_size'(1) : wr_ptr_q;
        rd_ptr_d     = flush ? '0 : rd_acc ? rd_ptr_q + addr_size'(1) : rd_ptr_q;
        // push and pop together leave the count unchanged
        cnt_d        = flush ? '0 : (wr_acc != rd_acc) ? (wr_acc ? cnt_q + CW'(1) : cnt_q - CW'(1)) : cnt_q;
        rdata_d      = rd_acc ? mem_q[rd_ptr_q] : rdata_q;
        rvalid_d     = rd_acc;
        ovf_d        = (write_en && fifo_full && !flush) || (ovf_q && !clear_err);
        udf_d        = (read_en && fifo_empty && !flush) || (udf_q && !clear_err);
        // fwft head is forced to zero while empty so reset shows a defined word
        read_data    = (fwft != 0) ? (fifo_empty ? '0 : mem_q[rd_ptr_q]) : rdata_q;
        read_valid   = (fwft != 0) ? !fifo_empty : rvalid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= write_data;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed table-driven bench for sync_fifo in standard and fwft read modes
module tb_sync_fifo;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       we = 1'b0, re = 1'b0, fl = 1'b0, ce = 1'b0;
    logic [7:0] wd = '0;
    logic [7:0] rd0, rd1;
    logic       rv0, rv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
    logic [3:0] fc0, fc1;
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo #(.fwft(0)) u0 (
        .clk(clk), .rst_n(rst_n), .write_en(we), .write_data(wd), .read_en(re), .flush(fl),
        .clear_err(ce), .read_data(rd0), .read_valid(rv0), .fifo_full(full0), .fifo_empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .fill_count(fc0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo #(.fwft(1)) u1 (
        .clk(clk), .rst_n(rst_n), .write_en(we), .write_data(wd), .read_en(re), .flush(fl),
        .clear_err(ce), .read_data(rd1), .read_valid(rv1), .fifo_full(full1), .fifo_empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .fill_count(fc1), .overflow(ovf1), .underflow(udf1)
    );

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re, fl, ce;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t v(logic w, logic [7:0] d, logic r, logic f, logic c, logic [3:0] cnt,
                               logic full, logic empty, logic af, logic ae, logic o, logic u,
                               logic rv, logic [7:0] rd);
        vec_t t;
        t.we  = w;
        t.wd  = d;
        t.re  = r;
        t.fl  = f;
        t.ce  = c;
        t.exp = {cnt, full, empty, af, ae, o, u, rv, rd};
        return t;
    endfunction

    function automatic logic [18:0] obs0();
        return {fc0, full0, empty0, af0, ae0, ovf0, udf0, rv0, rd0};
    endfunction

    function automatic logic [18:0] obs1();
        return {fc1, full1, empty1, af1, ae1, ovf1, udf1, rv1, rd1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f, input logic c);
        we = w;
        wd = d;
        re = r;
        fl = f;
        ce = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          we wd     re fl ce  cnt  fu em af ae ov un rv rd
        tbl[0]  = v(1, 8'h10, 0, 0, 0, 4'd1, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        tbl[1]  = v(1, 8'h11, 0, 0, 0, 4'd2, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[2]  = v(1, 8'h12, 0, 0, 0, 4'd3, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[3]  = v(1, 8'h13, 0, 0, 0, 4'd4, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[4]  = v(1, 8'h14, 0, 0, 0, 4'd5, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[5]  = v(1, 8'h15, 0, 0, 0, 4'd6, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        tbl[6]  = v(1, 8'h16, 0, 0, 0, 4'd7, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        tbl[7]  = v(1, 8'h17, 0, 0, 0, 4'd8, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        tbl[8]  = v(1, 8'h99, 0, 0, 0, 4'd8, 1, 0, 1, 0, 1, 0, 0, 8'h00);
        tbl[9]  = v(0, 8'h00, 1, 0, 0, 4'd7, 0, 0, 1, 0, 1, 0, 1, 8'h10);
        tbl[10] = v(0, 8'h00, 1, 0, 0, 4'd6, 0, 0, 1, 0, 1, 0, 1, 8'h11);
        tbl[11] = v(0, 8'h00, 1, 0, 0, 4'd5, 0, 0, 0, 0, 1, 0, 1, 8'h12);
        tbl[12] = v(0, 8'h00, 1, 0, 0, 4'd4, 0, 0, 0, 0, 1, 0, 1, 8'h13);
        tbl[13] = v(0, 8'h00, 1, 0, 0, 4'd3, 0, 0, 0, 0, 1, 0, 1, 8'h14);
        tbl[14] = v(0, 8'h00, 1, 0, 0, 4'd2, 0, 0, 0, 0, 1, 0, 1, 8'h15);
        tbl[15] = v(0, 8'h00, 1, 0, 0, 4'd1, 0, 0, 0, 1, 1, 0, 1, 8'h16);
        tbl[16] = v(0, 8'h00, 1, 0, 0, 4'd0, 0, 1, 0, 1, 1, 0, 1, 8'h17);
        tbl[17] = v(0, 8'h00, 1, 0, 0, 4'd0, 0, 1, 0, 1, 1, 1, 0, 8'h17);
        tbl[18] = v(0, 8'h00, 0, 0, 1, 4'd0, 0, 1, 0, 1, 0, 0, 0, 8'h17);
        tbl[19] = v(1, 8'h20, 0, 0, 0, 4'd1, 0, 0, 0, 1, 0, 0, 0, 8'h17);

        #2;
        chk("reset_std", 32'(obs0()), 32'({4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        chk("reset_fwft", 32'(obs1()), 32'({4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        #10 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].fl, tbl[i].ce);
            chk($sformatf("vec%0d", i), 32'(obs0()), 32'(tbl[i].exp));
        end

        // fill to 4 (0x20 already in), then 20 push+pop cycles across the pointer wrap
        for (int i = 1; i < 4; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        chk("wrap_start_cnt", 32'(fc0), 32'd4);
        chk("wrap_start_head", 32'(rd1), 32'h20);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h24 + i), 1, 0, 0);
            chk($sformatf("wrap%0d_std", i), 32'({fc0, rv0, ovf0, udf0, rd0}),
                32'({4'd4, 1'b1, 1'b0, 1'b0, 8'(8'h20 + i)}));
            chk($sformatf("wrap%0d_fwft", i), 32'({fc1, rv1, rd1}), 32'({4'd4, 1'b1, 8'(8'h21 + i)}));
        end

        step(1, 8'h40, 0, 0, 0);
        chk("pre_flush_cnt", 32'(fc0), 32'd5);
        step(1, 8'h41, 1, 1, 0);
        chk("flush_std", 32'({fc0, empty0, ovf0, udf0, rv0, rd0}), 32'({4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33}));
        chk("flush_fwft", 32'({fc1, empty1, rv1}), 32'({4'd0, 1'b1, 1'b0}));
        step(0, 8'h00, 1, 0, 1);
        chk("udf_set_wins", 32'({udf0, udf1}), 32'b11);
        step(0, 8'h00, 0, 0, 1);
        chk("udf_cleared", 32'({udf0, udf1}), 32'b00);

        step(1, 8'hA5, 0, 0, 0);
        chk("fwft_fall", 32'({rv1, rd1, fc1}), 32'({1'b1, 8'hA5, 4'd1}));
        chk("std_no_fall", 32'(rv0), 32'd0);
        step(0, 8'h00, 1, 0, 0);
        chk("fwft_pop", 32'({empty1, rv1}), 32'b10);
        chk("std_pop", 32'({rv0, rd0, empty0}), 32'({1'b1, 8'hA5, 1'b1}));

        step(1, 8'h50, 0, 0, 0);
        step(1, 8'h51, 0, 0, 0);
        step(1, 8'h52, 1, 0, 0);
        step(1, 8'h53, 0, 0, 0);
        chk("pre_reset_cnt", 32'(fc0), 32'd3);
        we = 1'b0;
        re = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_std", 32'(obs0()), 32'({4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        chk("async_reset_fwft", 32'(obs1()), 32'({4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        #1 rst_n = 1'b1;
        step(1, 8'h55, 0, 0, 0);
        chk("post_reset_fwft", 32'({fc1, rv1, rd1}), 32'({4'd1, 1'b1, 8'h55}));
        step(0, 8'h00, 1, 0, 0);
        chk("post_reset_std", 32'({fc0, rv0, rd0}), 32'({4'd0, 1'b1, 8'h55}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
